fifo_stream_reader: RTL and testbench

//  Read-side master for the synchronous FIFO. Pops words via the FIFO rd/dout/empty

---
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: pops words through the 1-cycle registered
// read port and re-presents them as a valid/ready stream through a 3-entry skid buffer.
module fifo_stream_reader #(
    parameter int Width = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [Width-1:0] fifo_dout,
    output logic             fifo_rd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [Width-1:0] m_data,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    logic [Width-1:0] buf_reg [3];
    logic [1:0]       head_reg, head_next;
    logic [1:0]       tail_reg, tail_next;
    logic [1:0]       occ_reg, occ_next;
    logic             inflight_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [2:0]       pending;
    logic             capture;
    logic             xfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a buffer slot for every word already popped, so a capture never finds it full.
    assign pending    = {1'b0, occ_reg} + {2'b00, inflight_reg};
    assign fifo_rd    = ~rst & en & ~fifo_empty & (pending < 3'd3);
    assign capture    = inflight_reg;
    assign m_valid    = (occ_reg != 2'd0);
    assign m_data     = buf_reg[head_reg];
    assign xfer       = m_valid & m_ready;
    assign busy       = inflight_reg | m_valid;
    assign word_count = count_reg;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        occ_next   = occ_reg;
        count_next = count_reg;
        if (capture) begin
            tail_next = ptr_inc(tail_reg);
        end
        if (xfer) begin
            head_next  = ptr_inc(head_reg);
            count_next = count_reg + CNT_W'(1);
        end
        case ({capture, xfer})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg     <= 2'd0;
            tail_reg     <= 2'd0;
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rd;
            count_reg    <= count_next;
        end
    end

    // Entries are cleared on reset so m_data reads zero while the buffer is empty after reset.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    buf_reg[gi] <= '0;
                end else if (capture && tail_reg == 2'(gi)) begin
                    buf_reg[gi] <= fifo_dout;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised and directed bench for fifo_stream_reader; a queue-based FIFO model feeds it
// and a scoreboard of popped words predicts every stream beat, flag and count.
module tb_fifo_stream_reader;

    localparam int W  = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_dout = '0;
    logic          fifo_rd;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic          busy;
    logic [CW-1:0] word_count;

    fifo_stream_reader #(.Width(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           avail;
    } exp_t;

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] wr_q [$];
    exp_t         exp_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int xfers = 0;
    int pops = 0;
    int pop_cyc = 0;
    int first_valid = -1;
    int last_xfer = -1;
    logic pop_now = 1'b0;
    logic rst_s = 1'b1, en_s = 1'b0, ready_s = 1'b0;
    logic samp_valid, samp_rd, samp_busy;
    logic [W-1:0] samp_data;
    logic have_prev = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [W-1:0] first_after;
    int t0;

    // Behavioural FIFO: pops on the edge after rd & ~empty was seen, registered dout.
    always @(posedge clk) begin
        logic [W-1:0] w;
        if (pop_now) begin
            w = fifo_q.pop_front();
            fifo_dout <= w;
            exp_q.push_back('{data: w, avail: pop_cyc + 2});
        end
        while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        wr_q.push_back(w);
    endtask

    task automatic clear_model();
        exp_q.delete();
        xfers = 0;
        have_prev = 1'b0;
    endtask

    // One clock cycle: apply inputs just after the edge, sample and score mid-cycle.
    task automatic cycle();
        logic exp_rd, exp_valid;
        logic [W-1:0] exp_data;
        @(posedge clk);
        #1;
        rst = rst_s;
        en = en_s;
        m_ready = ready_s;
        #2;
        if (rst) clear_model();
        exp_rd = !rst && en && !fifo_empty && (exp_q.size() < 3);
        exp_valid = 1'b0;
        exp_data = '0;
        if (exp_q.size() > 0 && exp_q[0].avail <= cyc) begin
            exp_valid = 1'b1;
            exp_data = exp_q[0].data;
        end
        check("fifo_rd", fifo_rd, exp_rd);
        check("m_valid", m_valid, exp_valid);
        if (exp_valid || rst) check("m_data", m_data, exp_data);
        check("busy", busy, exp_q.size() != 0);
        check("word_count", word_count, xfers % 32);
        check("occ_bound", 32'(dut.occ_reg) + 32'(dut.inflight_reg) <= 3, 1);
        if (have_prev && prev_valid && !prev_ready) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        pop_now = fifo_rd && !fifo_empty;
        pop_cyc = cyc;
        if (pop_now) pops++;
        if (exp_valid && m_ready) begin
            $display("beat %0d data=%02h cycle=%0d", xfers, exp_data, cyc);
            void'(exp_q.pop_front());
            xfers++;
            last_xfer = cyc;
        end
        have_prev = !rst;
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_data = m_data;
        samp_valid = m_valid;
        samp_data = m_data;
        samp_rd = fifo_rd;
        samp_busy = busy;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        cycle();
        rst_s = 1'b0;
        pops = 0;
        first_valid = -1;
    endtask

    task automatic preload16();
        for (int i = 1; i <= 16; i++) push(8'(i));
    endtask

    initial begin
        // Reset state
        run(2);
        check("rst_rd", fifo_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_count", word_count, 0);
        rst_s = 1'b0;

        // Streaming at full rate
        do_reset();
        preload16();
        en_s = 1'b1; ready_s = 1'b1;
        t0 = cyc;
        run(19);
        check("t2_first_valid", first_valid - t0, 2);
        check("t2_last_beat", last_xfer - t0, 17);
        check("t2_words", word_count, 16);
        check("t2_busy", samp_busy, 0);

        // Backpressure right from the first valid beat
        do_reset();
        preload16();
        en_s = 1'b1; ready_s = 1'b1;
        run(2);
        ready_s = 1'b0;
        run(10);
        check("t3_held_words", pops, 3);
        check("t3_head_data", samp_data, 8'h01);
        check("t3_rd_low", samp_rd, 0);
        ready_s = 1'b1;
        run(20);
        check("t3_delivered", word_count, 16);
        check("t3_busy", samp_busy, 0);

        // Underrun and resume
        do_reset();
        push(8'hA5); push(8'h5A);
        en_s = 1'b1; ready_s = 1'b1;
        run(8);
        check("t4_two_beats", word_count, 2);
        check("t4_valid_low", samp_valid, 0);
        check("t4_rd_low", samp_rd, 0);
        push(8'h3C);
        run(2);
        check("t4_not_yet", samp_valid, 0);
        run(1);
        check("t4_resume_valid", samp_valid, 1);
        check("t4_resume_data", samp_data, 8'h3C);
        run(2);

        // Enable drop after the fourth read
        do_reset();
        preload16();
        en_s = 1'b1; ready_s = 1'b1;
        run(4);
        en_s = 1'b0;
        run(10);
        check("t5_pops", pops, 4);
        check("t5_delivered", word_count, 4);
        check("t5_busy", samp_busy, 0);
        check("t5_fifo_left", fifo_q.size(), 12);
        en_s = 1'b1;
        run(20);

        // Asynchronous reset pulse between edges, mid-burst
        do_reset();
        preload16();
        en_s = 1'b1; ready_s = 1'b1;
        run(6);
        #1 rst = 1'b1;
        #1;
        check("ar_rd", fifo_rd, 0);
        check("ar_valid", m_valid, 0);
        check("ar_data", m_data, 0);
        check("ar_busy", busy, 0);
        check("ar_count", word_count, 0);
        clear_model();
        first_after = fifo_q[0];
        #1 rst = 1'b0;
        #1;
        pop_now = fifo_rd && !fifo_empty;
        pop_cyc = cyc - 1;
        run(2);
        check("ar_next_valid", samp_valid, 1);
        check("ar_next_data", samp_data, first_after);
        run(20);
        check("ar_restart_count", word_count, 32'(16 - 32'(first_after) + 1));

        // Random traffic, long enough to wrap the word counter
        do_reset();
        for (int i = 0; i < 500; i++) begin
            en_s = ($urandom_range(7) != 0);
            ready_s = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1 && fifo_q.size() + wr_q.size() < 24) push(8'($urandom));
            cycle();
        end
        en_s = 1'b1; ready_s = 1'b1;
        run(40);
        check("rnd_drained", fifo_q.size() + exp_q.size(), 0);
        check("rnd_busy", samp_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
